// File: rtl/seg_display_driver.sv
// Four-digit common-anode 7-segment driver: letter digit plus unsigned decimal of result,
// converted by a sequential double-dabble engine. Optional macro: SEG_LEADING_ZERO_BLANK_EN.
module seg_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] result,
    input  logic [3:0] m_3,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return adj;
    endfunction

    // Codes 0-9 are digits, A/b/C share the m_3 encoding, anything else is blank.
    function automatic logic [6:0] seg_pattern(input logic [3:0] code);
        case (code)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            default: return 7'b1111111;
        endcase
    endfunction

    state_t           state_r, state_s;
    logic [7:0]       cap_r;
    logic [7:0]       shreg_r;
    logic [11:0]      scratch_r;
    logic [11:0]      adj_s;
    logic [2:0]       bitcnt_r;
    logic [3:0]       hund_r, tens_r, ones_r;
    logic             busy_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [1:0]       digit_r;
    logic [3:0]       code_s;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;

    // Conversion state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic of the conversion FSM.
    always_comb begin
        state_s = state_r;
        adj_s   = bcd_adjust(scratch_r);
        case (state_r)
            ST_IDLE: begin
                if (result != cap_r) state_s = ST_SHIFT;
                else                 state_s = ST_IDLE;
            end
            ST_SHIFT: begin
                if (bitcnt_r == 3'd0) state_s = ST_DONE;
                else                  state_s = ST_SHIFT;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Double-dabble datapath; display registers only ever take a finished conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_r     <= 8'd0;
            shreg_r   <= 8'd0;
            scratch_r <= 12'd0;
            bitcnt_r  <= 3'd0;
            hund_r    <= 4'd0;
            tens_r    <= 4'd0;
            ones_r    <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (result != cap_r) begin
                        cap_r     <= result;
                        shreg_r   <= result;
                        scratch_r <= 12'd0;
                        bitcnt_r  <= 3'd7;
                    end
                end
                ST_SHIFT: begin
                    {scratch_r, shreg_r} <= {adj_s, shreg_r} << 1;
                    bitcnt_r             <= bitcnt_r - 3'd1;
                end
                ST_DONE: begin
                    hund_r <= scratch_r[11:8];
                    tens_r <= scratch_r[7:4];
                    ones_r <= scratch_r[3:0];
                end
                default: begin
                    bitcnt_r <= 3'd0;
                end
            endcase
        end
    end

    // busy tracks the state the FSM is entering, so it is high exactly in SHIFT and DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
        end
    end

    // Refresh divider and digit selector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= '0;
            digit_r   <= 2'd0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            digit_r   <= digit_r + 2'd1;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
            digit_r   <= digit_r;
        end
    end

    // Pick the code for the scanned digit; an unknown m_3 falls through to blank.
    always_comb begin
        code_s = 4'hF;
        case (digit_r)
            2'd0: code_s = ones_r;
            2'd1: begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
                if ((hund_r == 4'd0) && (tens_r == 4'd0)) code_s = 4'hF;
                else                                     code_s = tens_r;
`else
                code_s = tens_r;
`endif
            end
            2'd2: begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
                if (hund_r == 4'd0) code_s = 4'hF;
                else                code_s = hund_r;
`else
                code_s = hund_r;
`endif
            end
            2'd3: begin
                if ((m_3 == 4'hA) || (m_3 == 4'hB) || (m_3 == 4'hC)) code_s = m_3;
                else                                                code_s = 4'hF;
            end
            default: code_s = 4'hF;
        endcase
    end

    // Anode and segment registers update together so no digit ever shows a neighbour's pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r  <= 4'b1111;
            seg_r <= 7'b1111111;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= ~(4'b0001 << digit_r);
            seg_r <= seg_pattern(code_s);
            dp_r  <= 1'b1;
        end
    end

    assign an   = an_r;
    assign seg  = seg_r;
    assign dp   = dp_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench for seg_display_driver: stimulus pushes expected display contents,
// a monitor captures a full scan after each finished conversion and compares.
module tb_seg_display_driver;

    localparam int RD = 4;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [3:0] L_A = 4'b1010;
    localparam logic [3:0] L_B = 4'b1011;
    localparam logic [3:0] L_C = 4'b1100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] result = 8'd0;
    logic [3:0] m_3 = 4'b1111;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [27:0] sb_q[$];
    bit mon_en = 1'b0;
    bit mon_active = 1'b0;
    int cur = 0;

    seg_display_driver #(.REFRESH_DIV(RD)) dut (
        .clk(clk), .rst(rst), .result(result), .m_3(m_3),
        .an(an), .seg(seg), .dp(dp), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec_pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic [6:0] letter_pat(input logic [3:0] m);
        if (m === L_A) return 7'b0001000;
        if (m === L_B) return 7'b0000011;
        if (m === L_C) return 7'b1000110;
        return BLANK;
    endfunction

    // Expected {letter, hundreds, tens, units} segment patterns for value v.
    function automatic logic [27:0] model(input int v, input logic [3:0] m);
        logic [6:0] h, t, o;
        h = dec_pat(v / 100);
        t = dec_pat((v / 10) % 10);
        o = dec_pat(v % 10);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (v < 100) h = BLANK;
        if (v < 10)  t = BLANK;
`endif
        return {letter_pat(m), h, t, o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_mon();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || mon_active) && t < 200) begin
            tick(1);
            t++;
        end
        if (t >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_monitor: timeout with %0d entries pending", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic apply(input int v, input logic [3:0] m);
        m_3    = m;
        result = v[7:0];
        sb_q.push_back(model(v, m));
        cur = v;
        tick(1);
        wait_mon();
    endtask

    task automatic wait_an(input logic [3:0] target);
        int t;
        t = 0;
        tick(1);
        while (an !== target && t < 40) begin
            tick(1);
            t++;
        end
        check("wait_an", an, target);
    endtask

    // Monitor: after each busy fall, capture one full scan and compare with the scoreboard.
    initial begin : monitor
        logic prev_busy;
        logic [6:0] got [4];
        logic [27:0] exp_v;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && prev_busy === 1'b1 && busy === 1'b0) begin
                mon_active = 1'b1;
                for (int k = 0; k < 4; k++) got[k] = 7'bx;
                for (int i = 0; i < 4 * RD; i++) begin
                    @(negedge clk);
                    case (an)
                        4'b1110: got[0] = seg;
                        4'b1101: got[1] = seg;
                        4'b1011: got[2] = seg;
                        4'b0111: got[3] = seg;
                        default: ;
                    endcase
                end
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL monitor_unexpected: conversion ended with nothing expected");
                end else begin
                    exp_v = sb_q.pop_front();
                    check("display", {4'b0, got[3], got[2], got[1], got[0]}, {4'b0, exp_v});
                end
                prev_busy = busy;
                mon_active = 1'b0;
            end else begin
                prev_busy = busy;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [3:0] exp_an;
        logic [27:0] e100, e37, efin;
        logic [6:0] fin [4];
        int v, falls, bad;
        logic prevb;

        // Reset state
        tick(3);
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, BLANK);
        check("rst_busy", busy, 1'b0);
        check("rst_dp", dp, 1'b1);

        // First scan update and scan order
        m_3 = L_B;
        rst = 1'b0;
        tick(1);
        check("first_an", an, 4'b1110);
        check("first_seg", seg, dec_pat(0));
        for (int k = 2; k <= 32; k++) begin
            tick(1);
            exp_an = ~(4'b0001 << (((k - 1) / RD) % 4));
            check("scan_an", an, exp_an);
            if (exp_an == 4'b0111) check("scan_letter_b", seg, letter_pat(L_B));
        end
        m_3 = 4'b1111;
        wait_an(4'b0111);
        check("letter_blank", seg, BLANK);
        m_3 = 4'bxxxx;
        wait_an(4'b0111);
        check("letter_x_blank", seg, BLANK);

        // Conversion latency 0 -> 255
        mon_en = 1'b1;
        m_3 = L_A;
        result = 8'd255;
        sb_q.push_back(model(255, L_A));
        cur = 255;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            check("busy_latency", busy, (i <= 9) ? 1'b1 : 1'b0);
        end
        wait_mon();

        // Leading zeros and directed values
        apply(7, L_A);
        apply(0, L_C);
        apply(100, L_B);

        // Randomized values and letter codes
        for (int n = 0; n < 10; n++) begin
            v = $urandom_range(0, 255);
            while (v == cur) v = $urandom_range(0, 255);
            apply(v, 4'($urandom_range(9, 15)));
        end

        // Change of result mid-conversion
        if (cur == 100) apply(1, L_A);
        mon_en = 1'b0;
        m_3 = L_A;
        e100 = model(100, L_A);
        e37 = model(37, L_A);
        result = 8'd100;
        tick(3);
        result = 8'd37;
        cur = 37;
        falls = 0;
        bad = 0;
        prevb = busy;
        for (int k = 0; k < 4; k++) fin[k] = 7'bx;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (falls >= 1) begin
                case (an)
                    4'b1110: if (seg !== e100[6:0]   && seg !== e37[6:0])   bad++;
                    4'b1101: if (seg !== e100[13:7]  && seg !== e37[13:7])  bad++;
                    4'b1011: if (seg !== e100[20:14] && seg !== e37[20:14]) bad++;
                    default: ;
                endcase
            end
            if (prevb === 1'b1 && busy === 1'b0) falls++;
            prevb = busy;
            if (i >= 40) begin
                case (an)
                    4'b1110: fin[0] = seg;
                    4'b1101: fin[1] = seg;
                    4'b1011: fin[2] = seg;
                    4'b0111: fin[3] = seg;
                    default: ;
                endcase
            end
        end
        check("midconv_busy_falls", falls, 2);
        check("midconv_foreign_digits", bad, 0);
        efin = e37;
        check("midconv_final", {4'b0, fin[3], fin[2], fin[1], fin[0]}, {4'b0, efin});

        // Reset in the middle of a 0 -> 200 conversion
        mon_en = 1'b1;
        apply(0, L_A);
        mon_en = 1'b0;
        result = 8'd200;
        tick(5);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_an", an, 4'b1111);
        check("midrst_seg", seg, BLANK);
        check("midrst_busy", busy, 1'b0);
        check("midrst_dp", dp, 1'b1);
        tick(1);
        rst = 1'b0;
        mon_en = 1'b1;
        sb_q.push_back(model(200, L_A));
        cur = 200;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            check("busy_after_rst", busy, (i <= 9) ? 1'b1 : 1'b0);
        end
        wait_mon();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
